// File: rtl/cmd_uart_wrapper_pkg.sv
// Shared constants and state types for the knight command UART link.
package cmd_uart_wrapper_pkg;

  // Response bytes returned to the remote initiator
  localparam logic [7:0]  COMM_COMPLETE     = 8'hA5;
  localparam logic [7:0]  COMM_INTERMEDIATE = 8'h5A;

  // Command opcodes (cmd[15:12]) and full calibrate word
  localparam logic [3:0]  OP_CALIBRATE = 4'h0;
  localparam logic [3:0]  OP_MOVE      = 4'h2;
  localparam logic [3:0]  OP_TOUR      = 4'h4;
  localparam logic [15:0] CALIBRATE    = 16'h0000;

  // Heading codes (cmd[11:4])
  localparam logic [7:0]  HEAD_NORTH = 8'h00;
  localparam logic [7:0]  HEAD_WEST  = 8'h3F;
  localparam logic [7:0]  HEAD_SOUTH = 8'h7F;
  localparam logic [7:0]  HEAD_EAST  = 8'hBF;

  typedef enum logic [0:0] {WAIT_HI, WAIT_LO} asm_st_t;
  typedef enum logic [0:0] {TX_IDLE, TX_XMIT} tx_st_t;

endpackage

// File: rtl/cmd_uart_wrapper_if.sv
// Command-side handshake between the UART wrapper and cmd_proc.
interface cmd_uart_wrapper_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        trmt;
  logic        tx_done;

  // cmd_proc side
  modport master (input cmd, cmd_rdy, tx_done, output clr_cmd_rdy, resp, trmt);
  // wrapper side
  modport slave  (output cmd, cmd_rdy, tx_done, input clr_cmd_rdy, resp, trmt);
endinterface

// File: rtl/cmd_uart_wrapper_uart_byte_rx.sv
// 8N1 UART byte receiver: synchronizer, mid-bit sampling, done/framing-error pulses.
module uart_byte_rx #(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_err,
  output logic       rx_busy,
  output logic       rx_start
);
  localparam int CW = $clog2(BAUD_DIV + 1);

  logic [1:0]    sync;
  logic          rx_s, rx_prev;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;

  assign rx_s     = sync[1];
  // falling edge on an idle line starts a frame
  assign rx_start = !rx_busy && rx_prev && !rx_s;

  // two-flop synchronizer plus edge-detect history, preset to idle-high
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], rx};
      rx_prev <= rx_s;
    end
  end

  // baud timing and shifting; start sample at half bit, then every full bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_busy  <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_done  <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      rx_err  <= 1'b0;
      if (rx_start) begin
        rx_busy  <= 1'b1;
        baud_cnt <= CW'(BAUD_DIV / 2);
        bit_cnt  <= '0;
      end else if (rx_busy) begin
        if (baud_cnt == CW'(1)) begin
          baud_cnt <= CW'(BAUD_DIV);
          if (bit_cnt == 4'd9) begin
            // stop-bit sample: the start bit has already fallen out of shreg
            rx_busy <= 1'b0;
            rx_data <= shreg;
            rx_done <= rx_s;
            rx_err  <= !rx_s;
          end else begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end else begin
          baud_cnt <= baud_cnt - CW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/cmd_uart_wrapper.sv
// Knight-side UART wrapper: two-byte command assembly and 8N1 response transmit.
module cmd_uart_wrapper
  import cmd_uart_wrapper_pkg::*;
#(
  parameter int BAUD_DIV     = 5208,
  parameter int TIMEOUT_CLKS = 20 * BAUD_DIV
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RX,
  output logic               TX,
  cmd_uart_wrapper_if.slave  bus
);
  localparam int TCW = $clog2(BAUD_DIV + 1);
  localparam int TMW = $clog2(TIMEOUT_CLKS + 1);

  logic [7:0]     rx_data;
  logic           rx_done, rx_err, rx_busy, rx_start;

  asm_st_t        asm_st;
  logic [7:0]     hi_byte;
  logic [TMW-1:0] tmo_cnt;
  logic [15:0]    cmd_q;
  logic           cmd_rdy_q;

  tx_st_t         tx_st;
  logic [9:0]     tx_sh;
  logic [TCW-1:0] tx_cnt;
  logic [3:0]     tx_bit;
  logic           tx_done_q;

  uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (RX),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_err   (rx_err),
    .rx_busy  (rx_busy),
    .rx_start (rx_start)
  );

  assign bus.cmd     = cmd_q;
  assign bus.cmd_rdy = cmd_rdy_q;
  assign bus.tx_done = tx_done_q;
  // shifter LSB is the line; reset and idle fill keep it high
  assign TX          = tx_sh[0];

  // command assembly: high byte, then low byte within the idle timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_st    <= WAIT_HI;
      hi_byte   <= '0;
      tmo_cnt   <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      if (bus.clr_cmd_rdy) cmd_rdy_q <= 1'b0;
      if (rx_err) begin
        asm_st  <= WAIT_HI;
        tmo_cnt <= '0;
      end else begin
        case (asm_st)
          WAIT_HI: begin
            // a new command starting retires any stale ready flag
            if (rx_start) cmd_rdy_q <= 1'b0;
            if (rx_done) begin
              hi_byte <= rx_data;
              tmo_cnt <= '0;
              asm_st  <= WAIT_LO;
            end
          end
          WAIT_LO: begin
            if (rx_done) begin
              cmd_q     <= {hi_byte, rx_data};
              cmd_rdy_q <= 1'b1;
              asm_st    <= WAIT_HI;
            end else if (tmo_cnt == TMW'(TIMEOUT_CLKS)) begin
              asm_st  <= WAIT_HI;
              tmo_cnt <= '0;
            end else if (!rx_busy) begin
              tmo_cnt <= tmo_cnt + TMW'(1);
            end
          end
          default: asm_st <= WAIT_HI;
        endcase
      end
    end
  end

  // transmitter: 10 bits of BAUD_DIV clocks each, trmt ignored while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st     <= TX_IDLE;
      tx_sh     <= '1;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_done_q <= 1'b0;
    end else begin
      case (tx_st)
        TX_IDLE: begin
          if (bus.trmt) begin
            tx_sh     <= {1'b1, bus.resp, 1'b0};
            tx_cnt    <= TCW'(BAUD_DIV - 1);
            tx_bit    <= '0;
            tx_done_q <= 1'b0;
            tx_st     <= TX_XMIT;
          end
        end
        TX_XMIT: begin
          if (tx_cnt == '0) begin
            tx_sh  <= {1'b1, tx_sh[9:1]};
            tx_cnt <= TCW'(BAUD_DIV - 1);
            if (tx_bit == 4'd9) begin
              tx_done_q <= 1'b1;
              tx_st     <= TX_IDLE;
            end else begin
              tx_bit <= tx_bit + 4'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - TCW'(1);
          end
        end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// Directed bench for cmd_uart_wrapper with a command scoreboard and TX waveform checks.
module tb_cmd_uart_wrapper;
  import cmd_uart_wrapper_pkg::*;

  localparam int B   = 16;
  localparam int TMO = 20 * B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;

  cmd_uart_wrapper_if bus();

  cmd_uart_wrapper #(.BAUD_DIV(B), .TIMEOUT_CLKS(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .RX  (rx),
    .TX  (tx),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic        rdy_prev = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: each rising cmd_rdy consumes one expected command
  always @(negedge clk) begin
    if (rst) begin
      rdy_prev = 1'b0;
    end else begin
      if (bus.cmd_rdy === 1'b1 && rdy_prev === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL rdy_unexpected: observed cmd %h expected no cmd_rdy", bus.cmd);
        end else begin
          check("sb_cmd", bus.cmd, exp_q.pop_front());
        end
      end
      rdy_prev = bus.cmd_rdy;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (B) @(negedge clk);
    end
    rx = stop;
    repeat (B) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic tx_frame(input logic [7:0] r);
    logic [9:0] frm;
    frm = {1'b1, r, 1'b0};
    @(negedge clk);
    bus.resp = r;
    bus.trmt = 1'b1;
    @(negedge clk);
    bus.trmt = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("tx_bit_first", {15'd0, tx}, {15'd0, frm[k]});
      if (k == 0) check("tx_done_clr", {15'd0, bus.tx_done}, 16'd0);
      if (k == 4) begin
        // retrigger mid-frame with a different byte; must be ignored
        bus.resp = ~r;
        bus.trmt = 1'b1;
        @(negedge clk);
        bus.trmt = 1'b0;
        repeat (B - 2) @(negedge clk);
      end else begin
        repeat (B - 1) @(negedge clk);
      end
      check("tx_bit_last", {15'd0, tx}, {15'd0, frm[k]});
      if (k == 9) check("tx_done_early", {15'd0, bus.tx_done}, 16'd0);
      @(negedge clk);
    end
    check("tx_done_set", {15'd0, bus.tx_done}, 16'd1);
    check("tx_idle", {15'd0, tx}, 16'd1);
    repeat (2 * B) @(negedge clk);
    check("tx_done_hold", {15'd0, bus.tx_done}, 16'd1);
    check("tx_idle_hold", {15'd0, tx}, 16'd1);
  endtask

  initial begin
    logic [7:0] pd;
    bus.clr_cmd_rdy = 1'b0;
    bus.resp        = 8'h00;
    bus.trmt        = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_tx", {15'd0, tx}, 16'd1);
    check("rst_cmd", bus.cmd, 16'h0000);
    check("rst_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
    check("rst_done", {15'd0, bus.tx_done}, 16'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // MOVE EAST 1, then acknowledge
    send_byte({OP_MOVE, HEAD_EAST[7:4]}, 1'b1);
    check("hi_only_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
    exp_q.push_back(16'h2BF1);
    send_byte(8'hF1, 1'b1);
    check("move_rdy", {15'd0, bus.cmd_rdy}, 16'd1);
    check("move_cmd", bus.cmd, 16'h2BF1);
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    check("clr_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
    check("clr_cmd_keep", bus.cmd, 16'h2BF1);
    repeat (B) @(negedge clk);

    // CALIBRATE then TOUR with zero inter-frame gap
    exp_q.push_back(CALIBRATE);
    exp_q.push_back(16'h4022);
    send_byte(CALIBRATE[15:8], 1'b1);
    send_byte(CALIBRATE[7:0], 1'b1);
    send_byte(8'h40, 1'b1);
    send_byte(8'h22, 1'b1);
    check("b2b_cmd", bus.cmd, 16'h4022);
    repeat (B) @(negedge clk);

    // orphan high byte times out; the next pair is a fresh command
    send_byte(8'h3B, 1'b1);
    repeat (TMO + 10) @(negedge clk);
    check("tmo_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
    check("tmo_cmd_keep", bus.cmd, 16'h4022);
    exp_q.push_back(16'h4022);
    send_byte(8'h40, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (B) @(negedge clk);

    // response transmit, complete code
    tx_frame(COMM_COMPLETE);

    // framing error after the high byte drops the partial command
    send_byte(8'h2B, 1'b1);
    send_byte(8'hF1, 1'b0);
    repeat (B) @(negedge clk);
    check("ferr_cmd_keep", bus.cmd, 16'h4022);
    exp_q.push_back(16'h2BF1);
    send_byte(8'h2B, 1'b1);
    send_byte(8'hF1, 1'b1);
    repeat (B) @(negedge clk);

    // reset during bit 4 of an RX frame and during a TX frame of 0x00
    pd = 8'h2B;
    @(negedge clk);
    bus.resp = 8'h00;
    bus.trmt = 1'b1;
    rx       = 1'b0;
    @(negedge clk);
    bus.trmt = 1'b0;
    repeat (B - 1) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = pd[i];
      repeat (B) @(negedge clk);
    end
    rx = pd[4];
    repeat (B / 2) @(negedge clk);
    check("pre_rst_tx", {15'd0, tx}, 16'd0);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", {15'd0, tx}, 16'd1);
    check("mid_rst_rdy", {15'd0, bus.cmd_rdy}, 16'd0);
    check("mid_rst_done", {15'd0, bus.tx_done}, 16'd0);
    check("mid_rst_cmd", bus.cmd, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back(16'h2BF1);
    send_byte(8'h2B, 1'b1);
    send_byte(8'hF1, 1'b1);
    check("post_rst_cmd", bus.cmd, 16'h2BF1);
    repeat (B) @(negedge clk);

    // response transmit, intermediate code
    tx_frame(COMM_INTERMEDIATE);

    repeat (4) @(negedge clk);
    check("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
